// File: rtl/vector_memory_arbiter.sv
// rtl/vector_memory_arbiter.sv - single-port memory arbiter: loader writes over two bursting readers
// Optional feature macro: VMEM_ARB_STATS_EN (adds stall_count_o statistics counter)
module vector_memory_arbiter #(
   parameter int BURST_MAX = 8
) (
   input  logic        clock_i,
   input  logic        clear_i,
   input  logic        ld_req_i,
   input  logic [9:0]  ld_address_i,
   input  logic [15:0] ld_data_i,
   output logic        ld_ack_o,
   input  logic        r0_req_i,
   input  logic [9:0]  r0_address_i,
   input  logic        r1_req_i,
   input  logic [9:0]  r1_address_i,
   output logic        r0_grant_o,
   output logic        r1_grant_o,
   output logic        r0_valid_o,
   output logic        r1_valid_o,
   output logic [15:0] r0_data_o,
   output logic [15:0] r1_data_o,
   output logic [9:0]  mem_address_o,
   output logic        mem_enable_o,
   output logic        mem_write_o,
   output logic [15:0] mem_wdata_o,
   input  logic [15:0] mem_rdata_i
`ifdef VMEM_ARB_STATS_EN
   ,
   output logic [15:0] stall_count_o
`endif
);

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_R0   = 2'd1;
   localparam logic [1:0] OWN_R1   = 2'd2;
   localparam logic [3:0] BMAX     = 4'(BURST_MAX);

   logic [1:0] owner_q, owner_d;
   logic [3:0] beats_q, beats_d;
   logic       rr_q, rr_d;          // 0 = R0 wins next idle tie, 1 = R1
   logic       r0_valid_q, r1_valid_q;

   logic       grant_any;
   logic       grant_sel;           // 0 = r0, 1 = r1
   logic       cur_is_r1;
   logic       own_req, oth_req;

   assign cur_is_r1 = (owner_q == OWN_R1);
   assign own_req   = cur_is_r1 ? r1_req_i : r0_req_i;
   assign oth_req   = cur_is_r1 ? r0_req_i : r1_req_i;

   // Arbitration: loader wins and freezes burst state; otherwise burst/round-robin rules
   always_comb begin
      ld_ack_o  = 1'b0;
      grant_any = 1'b0;
      grant_sel = 1'b0;
      owner_d   = owner_q;
      beats_d   = beats_q;
      rr_d      = rr_q;
      if (clear_i) begin
         owner_d = OWN_NONE;
         beats_d = 4'd0;
         rr_d    = 1'b0;
      end else if (ld_req_i) begin
         ld_ack_o = 1'b1;
      end else if (owner_q == OWN_R0 || owner_q == OWN_R1) begin
         if (own_req && (!oth_req || beats_q < BMAX)) begin
            grant_any = 1'b1;
            grant_sel = cur_is_r1;
            beats_d   = (beats_q >= BMAX) ? BMAX : beats_q + 4'd1;
         end else if (oth_req) begin
            grant_any = 1'b1;
            grant_sel = ~cur_is_r1;
            owner_d   = cur_is_r1 ? OWN_R0 : OWN_R1;
            beats_d   = 4'd1;
            rr_d      = cur_is_r1;
         end else begin
            owner_d = OWN_NONE;
            beats_d = 4'd0;
            rr_d    = ~cur_is_r1;
         end
      end else begin
         if (r0_req_i && r1_req_i) begin
            grant_any = 1'b1;
            grant_sel = rr_q;
         end else if (r0_req_i || r1_req_i) begin
            grant_any = 1'b1;
            grant_sel = r1_req_i;
         end
         if (r0_req_i || r1_req_i) begin
            owner_d = grant_sel ? OWN_R1 : OWN_R0;
            beats_d = 4'd1;
         end
      end
   end

   assign r0_grant_o = grant_any & ~grant_sel;
   assign r1_grant_o = grant_any &  grant_sel;

   // Memory port mux: zeros whenever no access is issued
   always_comb begin
      mem_enable_o  = 1'b0;
      mem_write_o   = 1'b0;
      mem_address_o = 10'd0;
      mem_wdata_o   = 16'd0;
      if (ld_ack_o) begin
         mem_enable_o  = 1'b1;
         mem_write_o   = 1'b1;
         mem_address_o = ld_address_i;
         mem_wdata_o   = ld_data_i;
      end else if (r0_grant_o) begin
         mem_enable_o  = 1'b1;
         mem_address_o = r0_address_i;
      end else if (r1_grant_o) begin
         mem_enable_o  = 1'b1;
         mem_address_o = r1_address_i;
      end
   end

   // Arbiter state and read-valid pipeline (valid follows grant by one cycle)
   always_ff @(posedge clock_i) begin
      if (clear_i) begin
         owner_q    <= OWN_NONE;
         beats_q    <= 4'd0;
         rr_q       <= 1'b0;
         r0_valid_q <= 1'b0;
         r1_valid_q <= 1'b0;
      end else begin
         owner_q    <= owner_d;
         beats_q    <= beats_d;
         rr_q       <= rr_d;
         r0_valid_q <= r0_grant_o;
         r1_valid_q <= r1_grant_o;
      end
   end

   assign r0_valid_o = r0_valid_q;
   assign r1_valid_o = r1_valid_q;
   assign r0_data_o  = r0_valid_q ? mem_rdata_i : 16'h0000;
   assign r1_data_o  = r1_valid_q ? mem_rdata_i : 16'h0000;

`ifdef VMEM_ARB_STATS_EN
   logic [15:0] stall_q;
   logic        stalled;

   assign stalled = (ld_req_i & ~ld_ack_o) | (r0_req_i & ~r0_grant_o) | (r1_req_i & ~r1_grant_o);

   // Saturating count of cycles where some requester waited
   always_ff @(posedge clock_i) begin
      if (clear_i) begin
         stall_q <= 16'd0;
      end else if (stalled && stall_q != 16'hFFFF) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_count_o = stall_q;
`endif

endmodule

// File: tb/tb_vector_memory_arbiter.sv
// tb/tb_vector_memory_arbiter.sv - self-checking bench for vector_memory_arbiter
module tb_vector_memory_arbiter;

   localparam int BURST_MAX = 8;

   logic        clock = 1'b0;
   logic        clear = 1'b1;
   logic        ld_req = 1'b0;
   logic [9:0]  ld_address = '0;
   logic [15:0] ld_data = '0;
   logic        r0_req = 1'b0, r1_req = 1'b0;
   logic [9:0]  r0_address = '0, r1_address = '0;
   logic        ld_ack, r0_grant, r1_grant, r0_valid, r1_valid;
   logic [15:0] r0_data, r1_data;
   logic [9:0]  mem_address;
   logic        mem_enable, mem_write;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = '0;
`ifdef VMEM_ARB_STATS_EN
   logic [15:0] stall_count;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   vector_memory_arbiter #(.BURST_MAX(BURST_MAX)) dut (
      .clock_i(clock), .clear_i(clear),
      .ld_req_i(ld_req), .ld_address_i(ld_address), .ld_data_i(ld_data), .ld_ack_o(ld_ack),
      .r0_req_i(r0_req), .r0_address_i(r0_address), .r1_req_i(r1_req), .r1_address_i(r1_address),
      .r0_grant_o(r0_grant), .r1_grant_o(r1_grant),
      .r0_valid_o(r0_valid), .r1_valid_o(r1_valid), .r0_data_o(r0_data), .r1_data_o(r1_data),
      .mem_address_o(mem_address), .mem_enable_o(mem_enable), .mem_write_o(mem_write),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
`ifdef VMEM_ARB_STATS_EN
      , .stall_count_o(stall_count)
`endif
   );

   // Memory attached to the DUT and an independent reference copy for the model
   logic [15:0] mem [1024];
   logic [15:0] ref_mem [1024];
   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i]     = 16'(i * 7) ^ 16'h5A5A;
         ref_mem[i] = 16'(i * 7) ^ 16'h5A5A;
      end
   end

   always @(posedge clock) begin
      if (mem_enable) begin
         if (mem_write) mem[mem_address] <= mem_wdata;
         else           mem_rdata <= mem[mem_address];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who holds the port, how long they have run, whose turn a tie is
   int          m_holder = -1;
   int          m_run = 0;
   int          m_turn = 0;
   int          m_prev = -1;
   logic [9:0]  m_prev_addr = '0;
   int          m_stall = 0;
   bit          started = 0;

   always @(posedge clock) started <= 1'b1;

   always @(negedge clock) begin
      int win;
      bit want [2];
      logic [9:0] addr [2];
      logic [31:0] e_addr, e_wdata;
      if (started) begin
         want[0] = r0_req; want[1] = r1_req;
         addr[0] = r0_address; addr[1] = r1_address;
         win = -1;
         if (clear)        win = -1;
         else if (ld_req)  win = 2;
         else if (m_holder < 0) begin
            if (want[0] && want[1]) win = m_turn;
            else if (want[0])       win = 0;
            else if (want[1])       win = 1;
         end else if (want[m_holder] && (!want[1-m_holder] || m_run < BURST_MAX)) win = m_holder;
         else if (want[1-m_holder]) win = 1 - m_holder;

         e_addr = 0; e_wdata = 0;
         if (win == 2) begin e_addr = 32'(ld_address); e_wdata = 32'(ld_data); end
         else if (win >= 0) e_addr = 32'(addr[win]);

         chk("ld_ack",   32'(ld_ack),   32'(win == 2));
         chk("r0_grant", 32'(r0_grant), 32'(win == 0));
         chk("r1_grant", 32'(r1_grant), 32'(win == 1));
         chk("mem_enable", 32'(mem_enable), 32'(win >= 0));
         chk("mem_write",  32'(mem_write),  32'(win == 2));
         chk("mem_address", 32'(mem_address), e_addr);
         chk("mem_wdata",   32'(mem_wdata),   e_wdata);
         chk("r0_valid", 32'(r0_valid), 32'(m_prev == 0));
         chk("r1_valid", 32'(r1_valid), 32'(m_prev == 1));
         chk("r0_data", 32'(r0_data), (m_prev == 0) ? 32'(ref_mem[m_prev_addr]) : 32'h0);
         chk("r1_data", 32'(r1_data), (m_prev == 1) ? 32'(ref_mem[m_prev_addr]) : 32'h0);
`ifdef VMEM_ARB_STATS_EN
         chk("stall_count", 32'(stall_count), 32'(m_stall));
`endif
         // advance model to next cycle
         if (clear) m_stall = 0;
         else if ((ld_req && win != 2) || (want[0] && win != 0) || (want[1] && win != 1))
            m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
         if (win == 2) ref_mem[ld_address] = ld_data;
         m_prev = (win == 0 || win == 1) ? win : -1;
         if (win == 0 || win == 1) m_prev_addr = addr[win];
         if (clear) begin
            m_holder = -1; m_run = 0; m_turn = 0;
         end else if (win == 2) begin
            // loader cycle leaves burst untouched
         end else if (win < 0) begin
            if (m_holder >= 0) m_turn = 1 - m_holder;
            m_holder = -1; m_run = 0;
         end else if (win == m_holder) begin
            m_run = (m_run + 1 > BURST_MAX) ? BURST_MAX : m_run + 1;
         end else begin
            if (m_holder >= 0) m_turn = m_holder;
            m_holder = win; m_run = 1;
         end
      end
   end

   // One cycle: observe grants mid-cycle, then move to just after next rising edge
   int code;
   task automatic step();
      @(negedge clock);
      code = ld_ack ? 2 : r0_grant ? 0 : r1_grant ? 1 : -1;
      @(posedge clock);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1; r0_req = 0; r1_req = 0; ld_req = 0;
      step();
      clear = 1'b0;
   endtask

   initial begin
      int n;
      int seq [20];
      step(); step();
      // reset: requests ignored while clear is high
      clear = 1'b1; r0_req = 1'b1;
      @(negedge clock);
      chk("reset_r0_grant", 32'(r0_grant), 32'h0);
      chk("reset_mem_enable", 32'(mem_enable), 32'h0);
      @(posedge clock); #1;
      clear = 1'b0; r0_req = 1'b0;
      @(negedge clock);
      chk("reset_r0_valid", 32'(r0_valid), 32'h0);
      @(posedge clock); #1;

      // single reader, three beats at 0x040
      r0_req = 1'b1; r0_address = 10'h040;
      n = 0;
      for (int i = 0; i < 3; i++) begin step(); if (code == 0) n++; end
      r0_req = 1'b0;
      chk("s29_grants", 32'(n), 32'd3);
      @(negedge clock);
      chk("s29_valid", 32'(r0_valid), 32'h1);
      chk("s29_data",  32'(r0_data),  32'h5B9A);
      @(posedge clock); #1;
      step(); step();

      // two readers contending from reset: 8/8/4
      do_clear();
      r0_req = 1; r0_address = 10'h010; r1_req = 1; r1_address = 10'h200;
      for (int i = 0; i < 20; i++) begin step(); seq[i] = code; end
      for (int i = 0; i < 20; i++)
         chk($sformatf("s30_seq%0d", i), 32'(seq[i]), (i >= 8 && i < 16) ? 32'd1 : 32'd0);

      // loader preempts r0 burst at beat 3
      do_clear();
      r0_req = 1; r1_req = 1;
      step(); step();
      ld_req = 1; ld_address = 10'h123; ld_data = 16'h1111;
      step();
      chk("s31_ld", 32'(code), 32'd2);
      ld_req = 0;
      n = 2;
      for (int i = 0; i < 8; i++) begin step(); if (code == 0) n++; end
      chk("s31_r0_total", 32'(n), 32'd8);
      step();
      chk("s31_then_r1", 32'(code), 32'd1);

      // write then read back through r1
      do_clear();
      ld_req = 1; ld_address = 10'h3FF; ld_data = 16'hBEEF;
      step();
      ld_req = 0; r1_req = 1; r1_address = 10'h3FF;
      step();
      chk("s32_grant", 32'(code), 32'd1);
      r1_req = 0;
      @(negedge clock);
      chk("s32_valid", 32'(r1_valid), 32'h1);
      chk("s32_data",  32'(r1_data),  32'hBEEF);
      chk("s32_r0_valid", 32'(r0_valid), 32'h0);
      @(posedge clock); #1;

      // clear in the middle of an r1 burst
      do_clear();
      r0_req = 1; r0_address = 10'h011; r1_req = 1; r1_address = 10'h022;
      for (int i = 0; i < 10; i++) step();
      clear = 1;
      step();
      chk("s33_no_grant", 32'(code), 32'hFFFFFFFF);
      clear = 0;
      @(negedge clock);
      chk("s33_r1_valid", 32'(r1_valid), 32'h0);
      chk("s33_r0_first", 32'(r0_grant), 32'h1);
      @(posedge clock); #1;

`ifdef VMEM_ARB_STATS_EN
      do_clear();
      r0_req = 1; r1_req = 1;
      for (int i = 0; i < 16; i++) step();
      r0_req = 0; r1_req = 0;
      @(negedge clock);
      chk("s34_stall16", 32'(stall_count), 32'd16);
      @(posedge clock); #1;
      do_clear();
      @(negedge clock);
      chk("s34_stall0", 32'(stall_count), 32'd0);
      @(posedge clock); #1;
`endif
      do_clear();
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
